regfile32: RTL and testbench



---
 rtl/regfile32_if.sv | 23 ++
 rtl/regfile32.sv | 56 +++++
 tb/tb_regfile32.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile32_if.sv
// Write and read port bundle for regfile32: one synchronous write port, two
// combinational read ports.
interface regfile32_if;
    logic        write_enable;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [4:0]  read_address1;
    logic [4:0]  read_address2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    modport master (
        output write_enable, write_address, write_data,
        output read_address1, read_address2,
        input  read_data1, read_data2
    );

    modport slave (
        input  write_enable, write_address, write_data,
        input  read_address1, read_address2,
        output read_data1, read_data2
    );
endinterface

// File: rtl/regfile32.sv
// 32x32 register file: decoded synchronous write, two asynchronous read muxes,
// register 0 hardwired to zero, optional write-to-read forwarding.
module regfile32 #(
    parameter bit BYPASS = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    regfile32_if.slave  bus
);

    logic [31:1] write_select;
    logic [31:0] store  [1:31];
    logic [31:0] mux_in [32];

    // Decoder output for index 0 does not exist, so address 0 never writes.
    always_comb begin
        write_select = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            write_select[i] = bus.write_enable && (bus.write_address == 5'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < 32; i++) begin
                store[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < 32; i++) begin
                if (write_select[i]) begin
                    store[i] <= bus.write_data;
                end
            end
        end
    end

    always_comb begin
        mux_in[0] = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            mux_in[i] = store[i];
        end
    end

    logic forward1;
    logic forward2;

    always_comb begin
        forward1 = BYPASS && bus.write_enable && (bus.write_address != 5'd0)
                   && (bus.read_address1 == bus.write_address);
        forward2 = BYPASS && bus.write_enable && (bus.write_address != 5'd0)
                   && (bus.read_address2 == bus.write_address);
        bus.read_data1 = forward1 ? bus.write_data : mux_in[bus.read_address1];
        bus.read_data2 = forward2 ? bus.write_data : mux_in[bus.read_address2];
    end

endmodule

// File: tb/tb_regfile32.sv
// Bench for regfile32: drives a non-forwarding and a forwarding instance in
// lockstep and compares both against an array model of the register file.
module tb_regfile32;

    logic clk;
    logic reset;

    regfile32_if bus0();
    regfile32_if bus1();

    regfile32 #(.BYPASS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    regfile32 #(.BYPASS(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [31:0] model [32];
    logic        cur_we;
    logic [4:0]  cur_wa;
    logic [31:0] cur_wd;

    function automatic logic [31:0] expect_rd(input bit byp, input logic [4:0] ra);
        if (byp && cur_we && cur_wa != 5'd0 && ra == cur_wa) return cur_wd;
        if (ra == 5'd0) return 32'h0;
        return model[ra];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        cur_we = we; cur_wa = wa; cur_wd = wd;
        bus0.write_enable = we; bus0.write_address = wa; bus0.write_data = wd;
        bus1.write_enable = we; bus1.write_address = wa; bus1.write_data = wd;
        bus0.read_address1 = r1; bus0.read_address2 = r2;
        bus1.read_address1 = r1; bus1.read_address2 = r2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset && cur_we && cur_wa != 5'd0) model[cur_wa] = cur_wd;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int a = 0; a < 32; a += 7) begin
            drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            checks++;
            if (bus0.read_data1 !== 32'h0 || bus0.read_data2 !== 32'h0) begin
                fails++;
                $display("FAIL reset_state addr=%0d got %h/%h expected 0", a, bus0.read_data1, bus0.read_data2);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_clear();
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        checks++;
        if (bus0.read_data1 !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL reset_clear_pre got %h expected deadbeef", bus0.read_data1);
        end
        #1 reset = 1'b1;
        clear_model();
        #1;
        checks++;
        if (bus0.read_data1 !== 32'h0 || bus1.read_data1 !== 32'h0) begin
            fails++;
            $display("FAIL reset_async_clear got %h/%h expected 0", bus0.read_data1, bus1.read_data1);
        end
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        checks++;
        if (bus0.read_data1 !== 32'h0 || bus0.read_data2 !== 32'h0) begin
            fails++;
            $display("FAIL zero_reg_nobypass got %h/%h expected 0", bus0.read_data1, bus0.read_data2);
        end
        checks++;
        if (bus1.read_data1 !== 32'h0 || bus1.read_data2 !== 32'h0) begin
            fails++;
            $display("FAIL zero_reg_bypass got %h/%h expected 0", bus1.read_data1, bus1.read_data2);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checks++;
        if (bus0.read_data1 !== 32'h0 || bus1.read_data2 !== 32'h0) begin
            fails++;
            $display("FAIL zero_reg_after got %h/%h expected 0", bus0.read_data1, bus1.read_data2);
        end
    endtask

    task automatic test_sweep();
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0);
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            logic [31:0] e1;
            logic [31:0] e2;
            e1 = 32'(i) * 32'h0101_0101;
            e2 = 32'(31 - i) * 32'h0101_0101;
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            checks++;
            if (bus0.read_data1 !== e1 || bus1.read_data1 !== e1) begin
                fails++;
                $display("FAIL sweep_port1 addr=%0d got %h/%h expected %h", i, bus0.read_data1, bus1.read_data1, e1);
            end
            checks++;
            if (bus0.read_data2 !== e2 || bus1.read_data2 !== e2) begin
                fails++;
                $display("FAIL sweep_port2 addr=%0d got %h/%h expected %h", 31 - i, bus0.read_data2, bus1.read_data2, e2);
            end
        end
    endtask

    task automatic test_disabled_write();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd7);
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        checks++;
        if (bus0.read_data1 !== 32'h0707_0707 || bus1.read_data2 !== 32'h0707_0707) begin
            fails++;
            $display("FAIL disabled_write got %h/%h expected 07070707", bus0.read_data1, bus1.read_data2);
        end
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 5'd9, 32'hAAAA_AAAA, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd9, 32'h5555_5555, 5'd9, 5'd9);
        checks++;
        if (bus0.read_data1 !== 32'hAAAA_AAAA || bus0.read_data2 !== 32'hAAAA_AAAA) begin
            fails++;
            $display("FAIL same_cycle_old got %h/%h expected aaaaaaaa", bus0.read_data1, bus0.read_data2);
        end
        checks++;
        if (bus1.read_data1 !== 32'h5555_5555 || bus1.read_data2 !== 32'h5555_5555) begin
            fails++;
            $display("FAIL same_cycle_forward got %h/%h expected 55555555", bus1.read_data1, bus1.read_data2);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        checks++;
        if (bus0.read_data1 !== 32'h5555_5555 || bus0.read_data2 !== 32'h5555_5555) begin
            fails++;
            $display("FAIL same_cycle_after got %h/%h expected 55555555", bus0.read_data1, bus0.read_data2);
        end
    endtask

    task automatic test_collision();
        reset = 1'b1;
        clear_model();
        drive(1'b1, 5'd3, 32'hCAFE_F00D, 5'd3, 5'd3);
        tick();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        checks++;
        if (bus0.read_data1 !== 32'h0 || bus1.read_data2 !== 32'h0) begin
            fails++;
            $display("FAIL collision_lost got %h/%h expected 0", bus0.read_data1, bus1.read_data2);
        end
        drive(1'b1, 5'd3, 32'h1357_2468, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        checks++;
        if (bus0.read_data1 !== 32'h1357_2468 || bus1.read_data2 !== 32'h1357_2468) begin
            fails++;
            $display("FAIL collision_next_write got %h/%h expected 13572468", bus0.read_data1, bus1.read_data2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            logic [4:0] wa;
            logic [4:0] r1;
            logic [4:0] r2;
            wa = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, $urandom, r1, r2);
            checks++;
            if (bus0.read_data1 !== expect_rd(1'b0, r1) || bus0.read_data2 !== expect_rd(1'b0, r2)) begin
                fails++;
                $display("FAIL random_nobypass n=%0d got %h/%h expected %h/%h", n,
                         bus0.read_data1, bus0.read_data2, expect_rd(1'b0, r1), expect_rd(1'b0, r2));
            end
            checks++;
            if (bus1.read_data1 !== expect_rd(1'b1, r1) || bus1.read_data2 !== expect_rd(1'b1, r2)) begin
                fails++;
                $display("FAIL random_bypass n=%0d got %h/%h expected %h/%h", n,
                         bus1.read_data1, bus1.read_data2, expect_rd(1'b1, r1), expect_rd(1'b1, r2));
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_model();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        test_reset();
        test_reset_clear();
        test_zero_reg();
        test_sweep();
        test_disabled_write();
        test_same_cycle();
        test_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
